alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the 8-bit combinational datapath ALU. It accepts one operation per start/ready handshake and captures its operands at acceptance. It executes single-cycle ops in one cycle, and shifts and multiply iteratively. Results and flags are held in registers until the next operation completes. It sits between the register-file read ports and the write-back/branch-condition logic of the processor datapath.

---
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq.sv | 209 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/ready request and result/flag bundle for alu_seq.
// The master drives the request; the slave (alu_seq) returns result and flags.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start_i;
    logic [3:0]       opcode_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             cb_o;
    logic             ovf_o;
    logic             err_o;

    modport master (
        output start_i, opcode_i, rs_i, rt_i,
        input  ready_o, done_o, result_o, cb_o, ovf_o, err_o
    );

    modport slave (
        input  start_i, opcode_i, rs_i, rt_i,
        output ready_o, done_o, result_o, cb_o, ovf_o, err_o
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU, one op per start/ready handshake, iterative shifts.
// Define ALU_MUL_EN to make opcode 4'b1000 an iterative shift-add multiply.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic      clk_i,
    input logic      rst_i,
    alu_seq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [3:0] OpAnd = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSll = 4'h2;
    localparam logic [3:0] OpSrl = 4'h3;
    localparam logic [3:0] OpSub = 4'h4;
    localparam logic [3:0] OpSlt = 4'h5;
    localparam logic [3:0] OpAbs = 4'h6;
    localparam logic [3:0] OpSeq = 4'h7;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OpMul = 4'h8;

    typedef enum logic [1:0] {StIdle, StShift, StMul} state_e;
`else
    typedef enum logic [1:0] {StIdle, StShift} state_e;
`endif

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic [SHW-1:0]   r_cnt, w_cnt_nxt;
    logic             r_sll, w_sll_nxt;
    logic             r_cb, w_cb_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_err, w_err_nxt;
    logic             r_done, w_done_nxt;

    logic [WIDTH-1:0] w_sum, w_diff, w_abs, w_first, w_step;
    logic [SHW-1:0]   w_amt;
    logic             w_rt_big, w_add_ovf, w_sub_ovf, w_abs_ovf;

    assign w_sum     = bus.rs_i + bus.rt_i;
    assign w_diff    = bus.rs_i - bus.rt_i;
    assign w_abs     = bus.rs_i[MSB] ? ({WIDTH{1'b0}} - bus.rs_i) : bus.rs_i;
    assign w_add_ovf = (bus.rs_i[MSB] == bus.rt_i[MSB]) && (w_sum[MSB] != bus.rs_i[MSB]);
    assign w_sub_ovf = (bus.rs_i[MSB] != bus.rt_i[MSB]) && (w_diff[MSB] != bus.rs_i[MSB]);
    assign w_abs_ovf = bus.rs_i[MSB] && !(|bus.rs_i[MSB-1:0]);
    assign w_rt_big  = |bus.rt_i[WIDTH-1:SHW];
    assign w_amt     = bus.rt_i[SHW-1:0];
    assign w_first   = (bus.opcode_i == OpSll) ? (bus.rs_i << 1) : (bus.rs_i >> 1);
    assign w_step    = r_sll ? (r_acc << 1) : (r_acc >> 1);

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] r_prod, w_prod_nxt, r_mcand, w_mcand_nxt, w_prod_step;
    logic [WIDTH-1:0]   r_mplier, w_mplier_nxt;

    assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : {2*WIDTH{1'b0}});
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_sll_nxt    = r_sll;
        w_result_nxt = r_result;
        w_cb_nxt     = r_cb;
        w_ovf_nxt    = r_ovf;
        w_err_nxt    = r_err;
        w_done_nxt   = 1'b0;
`ifdef ALU_MUL_EN
        w_prod_nxt   = r_prod;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
`endif
        unique case (r_state)
            StIdle: begin
                if (bus.start_i) begin
                    // Assume completion at this edge; multi-cycle launches undo it.
                    w_done_nxt = 1'b1;
                    w_ovf_nxt  = 1'b0;
                    w_err_nxt  = 1'b0;
                    case (bus.opcode_i)
                        OpAnd: w_result_nxt = bus.rs_i & bus.rt_i;
                        OpAdd: begin
                            w_result_nxt = w_sum;
                            w_ovf_nxt    = w_add_ovf;
                        end
                        OpSub: begin
                            w_result_nxt = w_diff;
                            w_ovf_nxt    = w_sub_ovf;
                        end
                        OpSlt: w_cb_nxt = (bus.rs_i < bus.rt_i);
                        OpSeq: w_cb_nxt = (bus.rs_i == bus.rt_i);
                        OpAbs: begin
                            w_result_nxt = w_abs;
                            w_ovf_nxt    = w_abs_ovf;
                        end
                        OpSll, OpSrl: begin
                            if (w_rt_big) begin
                                w_result_nxt = '0;
                            end else if (w_amt == '0) begin
                                w_result_nxt = bus.rs_i;
                            end else if (w_amt == SHW'(1)) begin
                                w_result_nxt = w_first;
                            end else begin
                                w_done_nxt  = 1'b0;
                                w_ovf_nxt   = r_ovf;
                                w_err_nxt   = r_err;
                                w_acc_nxt   = w_first;
                                w_cnt_nxt   = w_amt - SHW'(1);
                                w_sll_nxt   = (bus.opcode_i == OpSll);
                                w_state_nxt = StShift;
                            end
                        end
`ifdef ALU_MUL_EN
                        OpMul: begin
                            w_done_nxt   = 1'b0;
                            w_ovf_nxt    = r_ovf;
                            w_err_nxt    = r_err;
                            w_prod_nxt   = bus.rt_i[0] ? {{WIDTH{1'b0}}, bus.rs_i} : '0;
                            w_mcand_nxt  = {{(WIDTH-1){1'b0}}, bus.rs_i, 1'b0};
                            w_mplier_nxt = bus.rt_i >> 1;
                            w_cnt_nxt    = SHW'(WIDTH - 1);
                            w_state_nxt  = StMul;
                        end
`endif
                        default: begin
                            w_result_nxt = '0;
                            w_err_nxt    = 1'b1;
                        end
                    endcase
                end
            end
            StShift: begin
                w_acc_nxt = w_step;
                w_cnt_nxt = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_result_nxt = w_step;
                    w_ovf_nxt    = 1'b0;
                    w_err_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = StIdle;
                end
            end
`ifdef ALU_MUL_EN
            StMul: begin
                w_prod_nxt   = w_prod_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_cnt_nxt    = r_cnt - SHW'(1);
                if (r_cnt == SHW'(1)) begin
                    w_result_nxt = w_prod_step[WIDTH-1:0];
                    w_ovf_nxt    = |w_prod_step[2*WIDTH-1:WIDTH];
                    w_err_nxt    = 1'b0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = StIdle;
                end
            end
`endif
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= StIdle;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sll    <= 1'b0;
            r_result <= '0;
            r_cb     <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sll    <= w_sll_nxt;
            r_result <= w_result_nxt;
            r_cb     <= w_cb_nxt;
            r_ovf    <= w_ovf_nxt;
            r_err    <= w_err_nxt;
            r_done   <= w_done_nxt;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
        end
    end
`endif

    assign bus.ready_o  = (r_state == StIdle);
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
    assign bus.cb_o     = r_cb;
    assign bus.ovf_o    = r_ovf;
    assign bus.err_o    = r_err;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic reference model.
// Honours ALU_MUL_EN the same way as the design; a second WIDTH=16 instance covers width scaling.
module tb_alu_seq;
    localparam int W = 8;
    localparam longint MOD  = longint'(1) << W;
    localparam longint HALF = longint'(1) << (W - 1);

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    alu_seq_if #(.WIDTH(W))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(W)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus8)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus16)
    );

    always #5 clk = ~clk;

    // Expected effect of one accepted operation.
    typedef struct packed {
        int           lat;
        bit           wres;
        logic [W-1:0] res;
        bit           wcb;
        logic         cb;
        logic         ovf;
        logic         err;
    } exp_t;

    function automatic longint to_signed(input longint u);
        return (u >= HALF) ? u - MOD : u;
    endfunction

    function automatic exp_t model_op(input logic [3:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
        exp_t   e;
        longint ua, ub, sa, sb, full;
        ua = longint'(a);
        ub = longint'(b);
        sa = to_signed(ua);
        sb = to_signed(ub);
        e.lat = 1; e.wres = 1'b1; e.res = '0; e.wcb = 1'b0; e.cb = 1'b0;
        e.ovf = 1'b0; e.err = 1'b0;
        case (op)
            4'h0: e.res = a & b;
            4'h1: begin
                full  = sa + sb;
                e.res = W'(ua + ub);
                e.ovf = (full >= HALF) || (full < -HALF);
            end
            4'h2, 4'h3: begin
                if (ub < W) begin
                    e.res = (op == 4'h2) ? W'(ua << ub) : W'(ua >> ub);
                    e.lat = (ub == 0) ? 1 : int'(ub);
                end
            end
            4'h4: begin
                full  = sa - sb;
                e.res = W'(ua - ub);
                e.ovf = (full >= HALF) || (full < -HALF);
            end
            4'h5: begin e.wres = 1'b0; e.wcb = 1'b1; e.cb = (ua < ub); end
            4'h6: begin
                full  = (sa < 0) ? -sa : sa;
                e.res = W'(full);
                e.ovf = (sa == -HALF);
            end
            4'h7: begin e.wres = 1'b0; e.wcb = 1'b1; e.cb = (ua == ub); end
`ifdef ALU_MUL_EN
            4'h8: begin
                full  = ua * ub;
                e.res = W'(full);
                e.ovf = (full >= MOD);
                e.lat = W;
            end
`endif
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Cycle-level reference: remaining latency plus pending effect.
    exp_t         w_new, p_op;
    int           m_rem;
    logic         m_ready, m_done, m_cb, m_ovf, m_err;
    logic [W-1:0] m_res;

    assign w_new   = model_op(bus8.opcode_i, bus8.rs_i, bus8.rt_i);
    assign m_ready = (m_rem == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem <= 0; m_done <= 1'b0; m_res <= '0; m_cb <= 1'b0; m_ovf <= 1'b0;
            m_err <= 1'b0;
        end else if (m_rem != 0) begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 1);
            if (m_rem == 1) begin
                if (p_op.wres) m_res <= p_op.res;
                if (p_op.wcb) m_cb <= p_op.cb;
                m_ovf <= p_op.ovf;
                m_err <= p_op.err;
            end
        end else if (bus8.start_i) begin
            m_done <= (w_new.lat == 1);
            if (w_new.lat == 1) begin
                if (w_new.wres) m_res <= w_new.res;
                if (w_new.wcb) m_cb <= w_new.cb;
                m_ovf <= w_new.ovf;
                m_err <= w_new.err;
            end else begin
                m_rem <= w_new.lat - 1;
                p_op  <= w_new;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ready", 32'(bus8.ready_o), 32'(m_ready));
        chk("done", 32'(bus8.done_o), 32'(m_done));
        chk("result", 32'(bus8.result_o), 32'(m_res));
        chk("cb", 32'(bus8.cb_o), 32'(m_cb));
        chk("ovf", 32'(bus8.ovf_o), 32'(m_ovf));
        chk("err", 32'(bus8.err_o), 32'(m_err));
    end

    // Issue one op, optionally poke start while busy, then check latency and literal outcome.
    task automatic op_chk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int exp_lat, input logic [W-1:0] exp_res, input logic exp_cb,
                          input logic exp_ovf, input logic exp_err, input bit poke,
                          input string nm);
        int lat;
        @(negedge clk);
        for (int i = 0; i < 100 && !bus8.ready_o; i++) @(negedge clk);
        bus8.start_i = 1'b1; bus8.opcode_i = op; bus8.rs_i = a; bus8.rt_i = b;
        @(negedge clk);
        bus8.start_i = 1'b0;
        bus8.rs_i    = W'($urandom);
        bus8.rt_i    = W'($urandom);
        lat = 1;
        while (!bus8.done_o && lat < 100) begin
            if (poke && !bus8.ready_o) begin
                bus8.start_i = 1'b1; bus8.opcode_i = 4'h0; bus8.rs_i = '0; bus8.rt_i = '0;
            end
            @(negedge clk);
            bus8.start_i = 1'b0;
            lat++;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_res"}, 32'(bus8.result_o), 32'(exp_res));
        chk({nm, "_cb"}, 32'(bus8.cb_o), 32'(exp_cb));
        chk({nm, "_ovf"}, 32'(bus8.ovf_o), 32'(exp_ovf));
        chk({nm, "_err"}, 32'(bus8.err_o), 32'(exp_err));
    endtask

    initial begin
        int lat;
        logic [3:0] op;
        n_vec = 0; n_err = 0;
        clk = 1'b0; rst = 1'b0;
        bus8.start_i = 1'b0; bus8.opcode_i = '0; bus8.rs_i = '0; bus8.rt_i = '0;
        bus16.start_i = 1'b0; bus16.opcode_i = '0; bus16.rs_i = '0; bus16.rt_i = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(bus8.ready_o), 32'd1);
        chk("rst_result", 32'(bus8.result_o), 32'd0);

        // Back-to-back single-cycle ops with start held high.
        @(negedge clk);
        bus8.start_i = 1'b1; bus8.opcode_i = 4'h1; bus8.rs_i = 8'h7F; bus8.rt_i = 8'h01;
        @(negedge clk);
        chk("b2b_add_done", 32'(bus8.done_o), 32'd1);
        chk("b2b_add_res", 32'(bus8.result_o), 32'h80);
        chk("b2b_add_ovf", 32'(bus8.ovf_o), 32'd1);
        bus8.opcode_i = 4'h4; bus8.rs_i = 8'h00; bus8.rt_i = 8'h01;
        @(negedge clk);
        chk("b2b_sub_done", 32'(bus8.done_o), 32'd1);
        chk("b2b_sub_res", 32'(bus8.result_o), 32'hFF);
        chk("b2b_sub_ovf", 32'(bus8.ovf_o), 32'd0);
        bus8.opcode_i = 4'h0; bus8.rs_i = 8'hF0; bus8.rt_i = 8'h3C;
        @(negedge clk);
        bus8.start_i = 1'b0;
        chk("b2b_and_done", 32'(bus8.done_o), 32'd1);
        chk("b2b_and_res", 32'(bus8.result_o), 32'h30);

        op_chk(4'h3, 8'hB4, 8'd3, 3, 8'h16, 1'b0, 1'b0, 1'b0, 1'b1, "srl3");
        op_chk(4'h2, 8'hB4, 8'd0, 1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, "sll0");
        op_chk(4'h2, 8'hB4, 8'd9, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "sll9");
        op_chk(4'h2, 8'h81, 8'd7, 7, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, "sll7");
        op_chk(4'h3, 8'h00, 8'd0, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "clr");
        op_chk(4'h5, 8'h05, 8'hFA, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "slt");
        op_chk(4'h7, 8'h33, 8'h33, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, "seq_eq");
        op_chk(4'h7, 8'h33, 8'h34, 1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, "seq_ne");
        op_chk(4'h6, 8'h80, 8'h00, 1, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, "abs80");
        op_chk(4'h6, 8'hFB, 8'h00, 1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, "absFB");
`ifdef ALU_MUL_EN
        op_chk(4'h8, 8'h0D, 8'h0B, 8, 8'h8F, 1'b0, 1'b0, 1'b0, 1'b1, "mul_a");
        op_chk(4'h8, 8'h10, 8'h10, 8, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, "mul_b");
`else
        op_chk(4'h8, 8'h0D, 8'h0B, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "mul_off");
`endif
        op_chk(4'hF, 8'h12, 8'h34, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "illegal");
        op_chk(4'h1, 8'h01, 8'h02, 1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, "add_clr");

        // Asynchronous reset in the middle of a 5-step shift.
        @(negedge clk);
        bus8.start_i = 1'b1; bus8.opcode_i = 4'h2; bus8.rs_i = 8'h01; bus8.rt_i = 8'd5;
        @(negedge clk);
        bus8.start_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus8.ready_o), 32'd1);
        chk("mid_rst_done", 32'(bus8.done_o), 32'd0);
        chk("mid_rst_res", 32'(bus8.result_o), 32'd0);
        chk("mid_rst_flags", {29'd0, bus8.cb_o, bus8.ovf_o, bus8.err_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(bus8.done_o), 32'd0);
        end

        // Randomized traffic; the per-cycle compare against the model does the checking.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) op = 4'($urandom_range(2, 3));
            if ($urandom_range(0, 3) == 0) op = 4'h8;
            bus8.start_i  = ($urandom_range(0, 3) != 0);
            bus8.opcode_i = op;
            bus8.rs_i     = W'($urandom);
            bus8.rt_i     = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, W + 1))
                                                         : W'($urandom);
        end
        @(negedge clk);
        bus8.start_i = 1'b0;
        repeat (W + 2) @(negedge clk);

        // WIDTH=16 instance: add overflow and a 3-step srl.
        bus16.start_i = 1'b1; bus16.opcode_i = 4'h1; bus16.rs_i = 16'h7FFF; bus16.rt_i = 16'h0001;
        @(negedge clk);
        bus16.start_i = 1'b0;
        chk("w16_add_done", 32'(bus16.done_o), 32'd1);
        chk("w16_add_res", 32'(bus16.result_o), 32'h8000);
        chk("w16_add_ovf", 32'(bus16.ovf_o), 32'd1);
        bus16.start_i = 1'b1; bus16.opcode_i = 4'h3; bus16.rs_i = 16'hB400; bus16.rt_i = 16'd3;
        @(negedge clk);
        bus16.start_i = 1'b0;
        lat = 1;
        while (!bus16.done_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("w16_srl_lat", 32'(lat), 32'd3);
        chk("w16_srl_res", 32'(bus16.result_o), 32'h1680);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
